traceback_unit: RTL and testbench
=================================

Name: traceback_unit

Overview:
Reader side of the traceback path memory for the K=3 (4-state) Viterbi decoder. On a start request it snapshots the four 8-bit decision-bit vectors and the write count. It then walks the trellis backward one step per clock from a given start state and emits the decoded bits as a serial stream and as an assembled, chronologically ordered word. It sits between the path memory and the decoder output stage.

Parameters:
TB_DEPTH, 8, traceback window length; equals the decision vector width.
CNT_W, 4, width of the write-count input.

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  traceback request; sampled only in IDLE
start_state  input  2  trellis state the traceback begins from
wr_cnt  input  CNT_W  number of decision columns written by the path memory
dec00_i  input  TB_DEPTH  decision bits, state 00 (bit TB_DEPTH-1 newest)
dec01_i  input  TB_DEPTH  decision bits, state 01
dec10_i  input  TB_DEPTH  decision bits, state 10
dec11_i  input  TB_DEPTH  decision bits, state 11
busy  output  1  high from the cycle after start acceptance through the DONE cycle
tb_bit  output  1  decoded bit of the current step (reverse time order)
tb_bit_valid  output  1  qualifies tb_bit
data_o  output  TB_DEPTH  decoded bits; data_o[0] is the oldest; unused MSBs are 0
out_len  output  CNT_W  number of valid bits in data_o
end_state  output  2  state reached after the last step
out_valid  output  1  one-cycle pulse when data_o, out_len and end_state are valid

Behaviour:
- One clock domain (clk). Asynchronous active-low reset rst_n. All outputs are registered.
- Reset values: every output is 0. FSM enters IDLE. Snapshot registers are cleared.
- Reset asserted mid-operation aborts immediately. No out_valid is produced for the aborted traceback.
- State encoding: s = {u_t, u_t-1}.
- Decoded bit at each step = s[1].
- Predecessor = {s[0], d}, where d = decision bit of state s at the current column.
- FSM states: IDLE, TRACE, DONE.
- IDLE, start=1:
  - Latch all four decision vectors, start_state into the current-state register, and len = min(wr_cnt, TB_DEPTH).
  - Clear data_o and the step counter k.
  - If len=0, go to DONE; otherwise go to TRACE.
- TRACE, step k (0..len-1), one per cycle:
  - Read column TB_DEPTH-1-k of the snapshot vector selected by the current state.
  - tb_bit = s[1], tb_bit_valid = 1.
  - data_o[len-1-k] = s[1].
  - s <= predecessor.
  - After step len-1, go to DONE.
- DONE:
  - out_valid = 1 for one cycle, with out_len = len and end_state = the final s.
  - busy drops the next cycle; FSM returns to IDLE.
- data_o, out_len and end_state hold their values until the next accepted start.
- Latency: start sampled at cycle 0 gives out_valid at cycle len+1.
- start while busy is ignored, not queued. start in the DONE cycle is also ignored.
- Changes on dec*_i or wr_cnt after acceptance have no effect (snapshot).
- wr_cnt > TB_DEPTH (including a count that wrapped past the vector width) is clamped to TB_DEPTH.
- When len < TB_DEPTH, only columns TB_DEPTH-1 down to TB_DEPTH-len are read.

Decomposition:
- Shared package viterbi_pkg:
  - state constants S00, S01, S10, S11 (2-bit);
  - TB_DEPTH default;
  - function tb_predecessor(state, dec).
- One natural sub-module: tb_step. It is combinational: it selects the decision bit by state and column index and returns the decoded bit and next state.
- The FSM, counters and snapshot registers stay in traceback_unit.

Test Plan:
- All dec*=8'h00, wr_cnt=8, start_state=11: tb_bit sequence 1,1,0,0,0,0,0,0 -> data_o=8'hC0, out_len=8, end_state=00, out_valid at cycle 9.
- All dec*=8'hFF, wr_cnt=8, start_state=00: bits 0,0,1,1,1,1,1,1 -> data_o=8'h3F, end_state=11.
- All dec*=8'h00, wr_cnt=3, start_state=11: only columns 7,6,5 are read -> data_o=8'h06, out_len=3, out_valid at cycle 4. wr_cnt=12 -> same result as wr_cnt=8.
- wr_cnt=0, start_state=10: out_valid at cycle 1, data_o=8'h00, out_len=0, end_state=10, no tb_bit_valid.
- start re-asserted during TRACE and in the DONE cycle, and dec*_i toggled after acceptance: exactly one out_valid, with a result identical to the first scenario.
- rst_n low at step 4 of TRACE: all outputs 0 asynchronously, no out_valid. A fresh start afterwards completes normally.

Source files
------------

// File: rtl/viterbi_pkg.sv
// Shared definitions for the K=3 Viterbi decoder: trellis state names,
// default traceback depth, FSM encoding and the backward trellis step.
package viterbi_pkg;

    localparam logic [1:0] S00 = 2'b00;
    localparam logic [1:0] S01 = 2'b01;
    localparam logic [1:0] S10 = 2'b10;
    localparam logic [1:0] S11 = 2'b11;

    localparam int TB_DEPTH_DEFAULT = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        TRACE = 2'b01,
        DONE  = 2'b10
    } tb_fsm_e;

    // State is {u_t, u_t-1}; stepping back drops u_t and shifts in the decision bit.
    function automatic logic [1:0] tb_predecessor(input logic [1:0] state, input logic dec);
        return {state[0], dec};
    endfunction

endpackage

// File: rtl/tb_step.sv
// One combinational traceback step: picks the decision bit of the current
// state at the given column and produces the decoded bit and predecessor.
module tb_step
    import viterbi_pkg::*;
#(
    parameter int TB_DEPTH = TB_DEPTH_DEFAULT,
    parameter int IDX_W    = $clog2(TB_DEPTH)
) (
    input  logic [1:0]          state,
    input  logic [TB_DEPTH-1:0] dec00,
    input  logic [TB_DEPTH-1:0] dec01,
    input  logic [TB_DEPTH-1:0] dec10,
    input  logic [TB_DEPTH-1:0] dec11,
    input  logic [IDX_W-1:0]    col,
    output logic                bit_out,
    output logic [1:0]          next_state
);

    logic dec_bit;

    always_comb begin
        dec_bit = 1'b0;
        case (state)
            S00:     dec_bit = dec00[col];
            S01:     dec_bit = dec01[col];
            S10:     dec_bit = dec10[col];
            default: dec_bit = dec11[col];
        endcase
    end

    assign bit_out    = state[1];
    assign next_state = tb_predecessor(state, dec_bit);

endmodule

// File: rtl/traceback_unit.sv
// Traceback reader: snapshots the decision vectors on request, walks the
// trellis backward one column per clock and assembles the decoded word.
module traceback_unit
    import viterbi_pkg::*;
#(
    parameter int TB_DEPTH = TB_DEPTH_DEFAULT,
    parameter int CNT_W    = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [1:0]          start_state,
    input  logic [CNT_W-1:0]    wr_cnt,
    input  logic [TB_DEPTH-1:0] dec00_i,
    input  logic [TB_DEPTH-1:0] dec01_i,
    input  logic [TB_DEPTH-1:0] dec10_i,
    input  logic [TB_DEPTH-1:0] dec11_i,
    output logic                busy,
    output logic                tb_bit,
    output logic                tb_bit_valid,
    output logic [TB_DEPTH-1:0] data_o,
    output logic [CNT_W-1:0]    out_len,
    output logic [1:0]          end_state,
    output logic                out_valid
);

    localparam int IDX_W = $clog2(TB_DEPTH);

    tb_fsm_e state, state_next;

    logic [TB_DEPTH-1:0] snap00, snap01, snap10, snap11;
    logic [1:0]          cur_s;
    logic [CNT_W-1:0]    len_r;
    logic [CNT_W-1:0]    k_r;

    logic [CNT_W-1:0]    len_clamped;
    logic                accept;
    logic                last_step;
    logic [IDX_W-1:0]    col;
    logic [IDX_W-1:0]    dat_idx;
    logic                step_bit;
    logic [1:0]          step_next;

    // busy still covers the out_valid cycle, so a start there is not taken
    assign accept      = (state == IDLE) && start && !busy;
    assign len_clamped = (wr_cnt > CNT_W'(TB_DEPTH)) ? CNT_W'(TB_DEPTH) : wr_cnt;
    assign last_step   = (k_r == len_r - CNT_W'(1));
    assign col         = IDX_W'(TB_DEPTH - 1) - k_r[IDX_W-1:0];
    assign dat_idx     = len_r[IDX_W-1:0] - IDX_W'(1) - k_r[IDX_W-1:0];

    tb_step #(
        .TB_DEPTH (TB_DEPTH),
        .IDX_W    (IDX_W)
    ) u_step (
        .state      (cur_s),
        .dec00      (snap00),
        .dec01      (snap01),
        .dec10      (snap10),
        .dec11      (snap11),
        .col        (col),
        .bit_out    (step_bit),
        .next_state (step_next)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = (len_clamped == '0) ? DONE : TRACE;
            TRACE:   if (last_step) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            snap00       <= '0;
            snap01       <= '0;
            snap10       <= '0;
            snap11       <= '0;
            cur_s        <= S00;
            len_r        <= '0;
            k_r          <= '0;
            busy         <= 1'b0;
            tb_bit       <= 1'b0;
            tb_bit_valid <= 1'b0;
            data_o       <= '0;
            out_len      <= '0;
            end_state    <= S00;
            out_valid    <= 1'b0;
        end else begin
            tb_bit       <= 1'b0;
            tb_bit_valid <= 1'b0;
            out_valid    <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        snap00 <= dec00_i;
                        snap01 <= dec01_i;
                        snap10 <= dec10_i;
                        snap11 <= dec11_i;
                        cur_s  <= start_state;
                        len_r  <= len_clamped;
                        k_r    <= '0;
                        data_o <= '0;
                        busy   <= 1'b1;
                    end else begin
                        busy   <= 1'b0;
                    end
                end
                TRACE: begin
                    tb_bit          <= step_bit;
                    tb_bit_valid    <= 1'b1;
                    data_o[dat_idx] <= step_bit;
                    cur_s           <= step_next;
                    k_r             <= k_r + CNT_W'(1);
                end
                DONE: begin
                    out_valid <= 1'b1;
                    out_len   <= len_r;
                    end_state <= cur_s;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_traceback_unit.sv
// Directed bench for traceback_unit: a vector table of traceback scenarios
// plus hand-written sequences for start-while-busy and mid-trace reset.
module tb_traceback_unit;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [1:0] start_state;
    logic [3:0] wr_cnt;
    logic [7:0] dec00_i, dec01_i, dec10_i, dec11_i;
    logic       busy;
    logic       tb_bit;
    logic       tb_bit_valid;
    logic [7:0] data_o;
    logic [3:0] out_len;
    logic [1:0] end_state;
    logic       out_valid;

    int n_checks;
    int n_fail;

    traceback_unit #(
        .TB_DEPTH (8),
        .CNT_W    (4)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .start_state  (start_state),
        .wr_cnt       (wr_cnt),
        .dec00_i      (dec00_i),
        .dec01_i      (dec01_i),
        .dec10_i      (dec10_i),
        .dec11_i      (dec11_i),
        .busy         (busy),
        .tb_bit       (tb_bit),
        .tb_bit_valid (tb_bit_valid),
        .data_o       (data_o),
        .out_len      (out_len),
        .end_state    (end_state),
        .out_valid    (out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] d00, d01, d10, d11;
        logic [3:0] wr;
        logic [1:0] ss;
        logic [7:0] exp_data;
        logic [3:0] exp_len;
        logic [1:0] exp_end;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic load_inputs(input vec_t v);
        dec00_i     = v.d00;
        dec01_i     = v.d01;
        dec10_i     = v.d10;
        dec11_i     = v.d11;
        wr_cnt      = v.wr;
        start_state = v.ss;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("wait_idle", {31'd0, busy}, 32'd0);
    endtask

    // Pulse start for one cycle and follow the traceback until out_valid.
    task automatic run_vector(input string name, input vec_t v);
        int         cyc;
        int         n_valid;
        logic [7:0] seq;
        logic       seen;
        wait_idle();
        load_inputs(v);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check({name, " busy"}, {31'd0, busy}, 32'd1);
        cyc     = 0;
        n_valid = 0;
        seq     = 8'h00;
        seen    = 1'b0;
        for (int n = 1; n <= 20 && !seen; n++) begin
            @(posedge clk);
            #1;
            if (tb_bit_valid) begin
                seq = {seq[6:0], tb_bit};
                n_valid++;
            end
            if (out_valid) begin
                seen = 1'b1;
                cyc  = n;
            end
        end
        check({name, " out_valid seen"}, {31'd0, seen}, 32'd1);
        check({name, " latency"}, cyc, 32'(v.exp_len) + 32'd1);
        check({name, " data_o"}, {24'd0, data_o}, {24'd0, v.exp_data});
        check({name, " out_len"}, {28'd0, out_len}, {28'd0, v.exp_len});
        check({name, " end_state"}, {30'd0, end_state}, {30'd0, v.exp_end});
        check({name, " tb_bit stream"}, {24'd0, seq}, {24'd0, v.exp_data});
        check({name, " tb_bit count"}, n_valid, 32'(v.exp_len));
    endtask

    initial begin
        vec_t v;
        int   pulses;
        int   cyc;

        n_checks    = 0;
        n_fail      = 0;
        rst_n       = 1'b0;
        start       = 1'b0;
        start_state = 2'b00;
        wr_cnt      = 4'd0;
        dec00_i     = 8'h00;
        dec01_i     = 8'h00;
        dec10_i     = 8'h00;
        dec11_i     = 8'h00;

        //            d00    d01    d10    d11   wr     ss     data   len    end
        vecs[0] = '{8'h00, 8'h00, 8'h00, 8'h00, 4'd8,  2'b11, 8'hC0, 4'd8, 2'b00};
        vecs[1] = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 4'd8,  2'b00, 8'h3F, 4'd8, 2'b11};
        vecs[2] = '{8'h00, 8'h00, 8'h00, 8'h00, 4'd3,  2'b11, 8'h06, 4'd3, 2'b00};
        vecs[3] = '{8'h00, 8'h00, 8'h00, 8'h00, 4'd12, 2'b11, 8'hC0, 4'd8, 2'b00};
        vecs[4] = '{8'h00, 8'h00, 8'h00, 8'h00, 4'd0,  2'b10, 8'h00, 4'd0, 2'b10};
        vecs[5] = '{8'hA5, 8'h3C, 8'h0F, 8'hF0, 4'd8,  2'b01, 8'h4D, 4'd8, 2'b01};
        vecs[6] = '{8'hA5, 8'h3C, 8'h0F, 8'hF0, 4'd5,  2'b01, 8'h09, 4'd5, 2'b10};
        vecs[7] = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 4'd15, 2'b00, 8'h3F, 4'd8, 2'b11};

        repeat (2) @(posedge clk);
        #1;
        check("reset busy", {31'd0, busy}, 32'd0);
        check("reset tb_bit_valid", {31'd0, tb_bit_valid}, 32'd0);
        check("reset data_o", {24'd0, data_o}, 32'd0);
        check("reset out_len", {28'd0, out_len}, 32'd0);
        check("reset out_valid", {31'd0, out_valid}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 8; i++) begin
            run_vector($sformatf("vec%0d", i), vecs[i]);
        end

        // Start held high across TRACE, DONE and the out_valid cycle, inputs disturbed
        wait_idle();
        load_inputs(vecs[0]);
        start = 1'b1;
        @(posedge clk);
        #1;
        dec00_i     = 8'hFF;
        dec01_i     = 8'hFF;
        dec10_i     = 8'hFF;
        dec11_i     = 8'hFF;
        wr_cnt      = 4'd2;
        start_state = 2'b00;
        pulses      = 0;
        cyc         = 0;
        for (int n = 1; n <= 9; n++) begin
            @(posedge clk);
            #1;
            if (out_valid) begin
                pulses++;
                cyc = n;
            end
        end
        start = 1'b0;
        for (int n = 10; n <= 14; n++) begin
            @(posedge clk);
            #1;
            if (out_valid) pulses++;
        end
        check("restart out_valid pulses", pulses, 32'd1);
        check("restart latency", cyc, 32'd9);
        check("restart data_o", {24'd0, data_o}, 32'h0000_00C0);
        check("restart out_len", {28'd0, out_len}, 32'd8);
        check("restart end_state", {30'd0, end_state}, 32'd0);

        // Reset asserted in the middle of a traceback
        wait_idle();
        load_inputs(vecs[1]);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("midreset busy", {31'd0, busy}, 32'd0);
        check("midreset tb_bit", {31'd0, tb_bit}, 32'd0);
        check("midreset tb_bit_valid", {31'd0, tb_bit_valid}, 32'd0);
        check("midreset data_o", {24'd0, data_o}, 32'd0);
        check("midreset out_len", {28'd0, out_len}, 32'd0);
        check("midreset end_state", {30'd0, end_state}, 32'd0);
        check("midreset out_valid", {31'd0, out_valid}, 32'd0);
        pulses = 0;
        for (int n = 0; n < 3; n++) begin
            @(posedge clk);
            #1;
            if (out_valid) pulses++;
        end
        rst_n = 1'b1;
        for (int n = 0; n < 8; n++) begin
            @(posedge clk);
            #1;
            if (out_valid) pulses++;
        end
        check("midreset no out_valid", pulses, 32'd0);
        run_vector("after reset", vecs[0]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
